// File: rtl/pd_vote_filter.sv
// Per-channel majority-vote filter for phase-detector bits.
// Emits one up/down decision per window and a lock/freeze flag.
module pd_vote_filter #(
  parameter int NCH      = 16,
  parameter int WIN_LOG2 = 3,
  parameter int LOCK_CNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCH-1:0]      pd_raw,
  input  logic [WIN_LOG2-2:0] dz,
  input  logic                freeze_clr,
  output logic [NCH-1:0]      pd_out,
  output logic [NCH-1:0]      freeze,
  output logic                pd_valid
);

  localparam int W  = 1 << WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam int LW = 4;

  localparam logic [WIN_LOG2-1:0] SLAST = WIN_LOG2'(W - 1);
  localparam logic [CW-1:0]       HALF  = CW'(W / 2);
  localparam logic [LW-1:0]       LMAX  = LW'(LOCK_CNT);

  logic [WIN_LOG2-1:0] scnt_q, scnt_d;
  logic [CW-1:0]       c_q    [NCH];
  logic [CW-1:0]       c_d    [NCH];
  logic [CW-1:0]       cf     [NCH];
  logic [LW-1:0]       lock_q [NCH];
  logic [LW-1:0]       lock_d [NCH];
  logic [LW-1:0]       lock_w [NCH];
  logic [NCH-1:0]      pd_out_q, pd_out_d;
  logic [NCH-1:0]      freeze_q, freeze_d;
  logic [NCH-1:0]      bal;
  logic                pd_valid_q, pd_valid_d;
  logic                win_end;
  logic [CW-1:0]       dz_x, lo, hi;

  assign win_end = enable & (scnt_q == SLAST);
  assign dz_x    = {2'b00, dz};
  assign lo      = HALF - dz_x;
  assign hi      = HALF + dz_x;

  // W is a power of two, so the counter wraps on its own
  assign scnt_d     = enable ? scnt_q + 1'b1 : scnt_q;
  assign pd_valid_d = win_end;

  always_comb begin
    pd_out_d = pd_out_q;
    freeze_d = freeze_q;
    bal      = '0;
    for (int i = 0; i < NCH; i++) begin
      cf[i]     = c_q[i] + {{(CW-1){1'b0}}, pd_raw[i]};
      c_d[i]    = c_q[i];
      lock_w[i] = lock_q[i];
      lock_d[i] = lock_q[i];
      bal[i]    = (cf[i] >= lo) && (cf[i] <= hi);
      if (enable)
        c_d[i] = win_end ? '0 : cf[i];
      if (win_end) begin
        if (cf[i] > HALF)
          pd_out_d[i] = 1'b1;
        else if (cf[i] < HALF)
          pd_out_d[i] = 1'b0;
        if (!bal[i])
          lock_w[i] = '0;
        else if (lock_q[i] != LMAX)
          lock_w[i] = lock_q[i] + 1'b1;
        lock_d[i]   = lock_w[i];
        freeze_d[i] = (lock_w[i] == LMAX);
      end
      // clear wins over the window-end lock update
      if (freeze_clr) begin
        lock_d[i]   = '0;
        freeze_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q     <= '0;
      pd_out_q   <= '0;
      freeze_q   <= '0;
      pd_valid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        c_q[i]    <= '0;
        lock_q[i] <= '0;
      end
    end else begin
      scnt_q     <= scnt_d;
      pd_out_q   <= pd_out_d;
      freeze_q   <= freeze_d;
      pd_valid_q <= pd_valid_d;
      for (int i = 0; i < NCH; i++) begin
        c_q[i]    <= c_d[i];
        lock_q[i] <= lock_d[i];
      end
    end
  end

  assign pd_out   = pd_out_q;
  assign freeze   = freeze_q;
  assign pd_valid = pd_valid_q;

endmodule

// File: tb/tb_pd_vote_filter.sv
// Randomized and directed bench for pd_vote_filter.
// Reference model stores whole windows and counts votes.
module tb_pd_vote_filter;

  localparam int NCH  = 16;
  localparam int WL   = 3;
  localparam int W    = 8;
  localparam int LOCK = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [NCH-1:0] pd_raw = '0;
  logic [WL-2:0]  dz = '0;
  logic           freeze_clr = 1'b0;
  logic [NCH-1:0] pd_out;
  logic [NCH-1:0] freeze;
  logic           pd_valid;

  pd_vote_filter #(
    .NCH(NCH), .WIN_LOG2(WL), .LOCK_CNT(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pd_raw(pd_raw), .dz(dz), .freeze_clr(freeze_clr),
    .pd_out(pd_out), .freeze(freeze), .pd_valid(pd_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [NCH-1:0] win [W];
  int             m_n;
  int             m_lock [NCH];
  int             m_dz;
  logic [NCH-1:0] m_out, m_frz;
  logic           m_valid;

  task automatic model_clear();
    m_n = 0;
    m_out = '0;
    m_frz = '0;
    m_valid = 1'b0;
    for (int c = 0; c < NCH; c++) m_lock[c] = 0;
  endtask

  task automatic model_edge(input bit en,
                            input logic [NCH-1:0] raw,
                            input bit clr);
    int cnt;
    bit b;
    m_valid = 1'b0;
    if (en) begin
      win[m_n] = raw;
      m_n++;
      if (m_n == W) begin
        for (int c = 0; c < NCH; c++) begin
          cnt = 0;
          for (int k = 0; k < W; k++) cnt += int'(win[k][c]);
          if (cnt > W / 2) m_out[c] = 1'b1;
          else if (cnt < W / 2) m_out[c] = 1'b0;
          b = (cnt >= W / 2 - m_dz) && (cnt <= W / 2 + m_dz);
          if (!b) m_lock[c] = 0;
          else if (m_lock[c] < LOCK) m_lock[c]++;
          m_frz[c] = (m_lock[c] == LOCK);
        end
        m_n = 0;
        m_valid = 1'b1;
      end
    end
    if (clr) begin
      for (int c = 0; c < NCH; c++) m_lock[c] = 0;
      m_frz = '0;
    end
  endtask

  task automatic step(input bit en,
                      input logic [NCH-1:0] raw,
                      input bit clr);
    enable = en;
    pd_raw = raw;
    freeze_clr = clr;
    @(posedge clk);
    model_edge(en, raw, clr);
    #1;
    chk("pd_out", 32'(pd_out), 32'(m_out));
    chk("freeze", 32'(freeze), 32'(m_frz));
    chk("pd_valid", 32'(pd_valid), 32'(m_valid));
  endtask

  task automatic do_reset(input logic [WL-2:0] ndz);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    freeze_clr = 1'b0;
    dz = ndz;
    m_dz = int'(ndz);
    #1;
    chk("rst_pd_out", 32'(pd_out), 32'h0);
    chk("rst_freeze", 32'(freeze), 32'h0);
    chk("rst_valid", 32'(pd_valid), 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [NCH-1:0] r;
  logic [7:0]     pat0, pat1;
  int             bias [NCH];

  initial begin
    model_clear();
    m_dz = 0;
    reset = 1'b1;
    #12;
    reset = 1'b0;

    // reset mid-window, then idle with enable low
    for (int s = 0; s < 3; s++) step(1'b1, 16'hFFFF, 1'b0);
    do_reset(2'd0);
    for (int s = 0; s < 20; s++) step(1'b0, 16'hFFFF, 1'b0);
    chk("idle_out", 32'(pd_out), 32'h0);

    // majority up/down, then tie hold on ch2
    pat0 = 8'b0111_1110;
    pat1 = 8'b0000_0101;
    for (int s = 0; s < W; s++) begin
      r = 16'($urandom);
      r[0] = pat0[s];
      r[1] = pat1[s];
      r[2] = 1'b1;
      step(1'b1, r, 1'b0);
      if (s == W - 2) chk("maj_pre_valid", 32'(pd_valid), 32'h0);
    end
    chk("maj_up", 32'(pd_out[0]), 32'h1);
    chk("maj_dn", 32'(pd_out[1]), 32'h0);
    chk("maj_valid", 32'(pd_valid), 32'h1);
    for (int s = 0; s < W; s++) begin
      r = 16'($urandom);
      r[2] = (s % 2 == 0);
      step(1'b1, r, 1'b0);
      if (s == 0) chk("valid_1cyc", 32'(pd_valid), 32'h0);
    end
    chk("tie_hold", 32'(pd_out[2]), 32'h1);

    // lock on ch3 with dz=1, then break it
    do_reset(2'd1);
    for (int s = 1; s <= 4 * W; s++) begin
      r = 16'($urandom);
      r[3] = (s % 2 == 1);
      step(1'b1, r, 1'b0);
      if (s == 4 * W - 1) chk("frz_pre", 32'(freeze[3]), 32'h0);
    end
    chk("frz_rise", 32'(freeze[3]), 32'h1);
    for (int s = 0; s < W; s++) begin
      r = 16'($urandom);
      r[3] = 1'b1;
      step(1'b1, r, 1'b0);
    end
    chk("frz_fall", 32'(freeze[3]), 32'h0);

    // all channels frozen, then freeze_clr on a window end
    do_reset(2'd1);
    for (int s = 0; s < 4 * W; s++)
      step(1'b1, (s % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b0);
    chk("frz_all", 32'(freeze), 32'hFFFF);
    for (int s = 0; s < W; s++)
      step(1'b1, (s < 5) ? 16'hFFFF : 16'h0000, s == W - 1);
    chk("clr_freeze", 32'(freeze), 32'h0);
    chk("clr_pd_out", 32'(pd_out), 32'hFFFF);

    // enable gap after the 3rd sample
    do_reset(2'd0);
    for (int s = 0; s < 13; s++) begin
      step(!(s >= 3 && s < 8), 16'($urandom), 1'b0);
      if (s == 11) chk("gap_pre", 32'(pd_valid), 32'h0);
    end
    chk("gap_end", 32'(pd_valid), 32'h1);

    // randomized run
    for (int blk = 0; blk < 6; blk++) begin
      do_reset(2'($urandom_range(0, 3)));
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0: bias[c] = 50;
          1: bias[c] = 20;
          2: bias[c] = 80;
          default: bias[c] = 45;
        endcase
      end
      for (int s = 0; s < 300; s++) begin
        for (int c = 0; c < NCH; c++)
          r[c] = ($urandom_range(0, 99) < bias[c]);
        step($urandom_range(0, 99) < 85, r,
             $urandom_range(0, 99) < 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
